// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the five-stage pipeline; shadow registers and FSM run on the falling edge.
// HAZARD_FWD_EN enables EX/MEM and MEM/WB operand forwarding; otherwise RAW hazards stall until retired.
module hazard_unit #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    Op,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  input  logic          MemRead_out_1,
  input  logic          RegWrite_out_2,
  input  logic          RegWrite_out,
  input  logic          branch_taken,
  input  logic          BranchJ_out,
  output logic          control_stall,
  output logic          control_stall_branch,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic [1:0]    forward_a,
  output logic [1:0]    forward_b
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t        state, nextState;
  logic [RW-1:0] dstId, dstEx, dstMem, dstWb;
  logic          rsUsed, rtUsed, matchEx, matchMem, matchWb, hazard, bubble;

  always_comb begin
    dstId = '0;
    if (Op == OP_R)
      dstId = rd;
    else if (Op == OP_LW || Op == OP_ADDI || Op == OP_ANDI || Op == OP_ORI ||
             Op == OP_XORI || Op == OP_SLTI)
      dstId = rt;
  end

  assign rsUsed = (Op != OP_J);
  assign rtUsed = (Op == OP_R) || (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_SW);

  // Register 0 is never a real destination, so it never matches.
  assign matchEx  = (dstEx  != '0) && ((rsUsed && rs == dstEx)  || (rtUsed && rt == dstEx));
  assign matchMem = (dstMem != '0) && ((rsUsed && rs == dstMem) || (rtUsed && rt == dstMem));
  assign matchWb  = (dstWb  != '0) && ((rsUsed && rs == dstWb)  || (rtUsed && rt == dstWb));

  assign bubble = control_stall || control_stall_branch;

`ifdef HAZARD_FWD_EN
  logic [RW-1:0] rsEx, rtEx;

  assign hazard = MemRead_out_1 && matchEx;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rsEx <= '0;
      rtEx <= '0;
    end else if (bubble) begin
      rsEx <= '0;
      rtEx <= '0;
    end else begin
      rsEx <= rs;
      rtEx <= rt;
    end
  end

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (RegWrite_out_2 && dstMem != '0 && dstMem == rsEx)
      forward_a = 2'b10;
    else if (RegWrite_out && dstWb != '0 && dstWb == rsEx)
      forward_a = 2'b01;
    if (RegWrite_out_2 && dstMem != '0 && dstMem == rtEx)
      forward_b = 2'b10;
    else if (RegWrite_out && dstWb != '0 && dstWb == rtEx)
      forward_b = 2'b01;
  end
`else
  logic unusedMemRead;

  assign unusedMemRead = MemRead_out_1;
  assign hazard    = matchEx || (RegWrite_out_2 && matchMem) || (RegWrite_out && matchWb);
  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      dstEx  <= '0;
      dstMem <= '0;
      dstWb  <= '0;
    end else begin
      dstEx  <= bubble ? '0 : dstId;
      dstMem <= dstEx;
      dstWb  <= dstMem;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  always_comb begin
    nextState = RUN;
    case (state)
      RUN, STALL: begin
        if (branch_taken) nextState = FLUSH;
        else if (hazard)  nextState = STALL;
        else              nextState = RUN;
      end
      FLUSH:   nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // Outputs are held at their reset values while reset is asserted, whatever the inputs do.
  always_comb begin
    control_stall        = 1'b0;
    control_stall_branch = 1'b0;
    pc_write             = 1'b1;
    ifid_write           = 1'b1;
    ifid_flush           = 1'b0;
    if (!reset) begin
      case (state)
        RUN, STALL: begin
          if (branch_taken) begin
            control_stall_branch = 1'b1;
            ifid_flush           = 1'b1;
          end else if (hazard) begin
            control_stall = 1'b1;
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
          end else if (BranchJ_out) begin
            ifid_flush = 1'b1;
          end
        end
        FLUSH: begin
          control_stall_branch = 1'b1;
          ifid_flush           = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and forwarding unit for the five-stage MIPS pipeline; the consumer of the control unit's stall inputs and its pipelined RegWrite/MemRead taps. Tracks destination register numbers through ID/EX, EX/MEM and MEM/WB shadow registers, detects load-use and branch hazards, and drives `control_stall` and `control_stall_branch` back into the control unit. Also drives PC/IF-ID write enables, IF/ID flush, and ALU operand forwarding selects.

## Interface
Parameters:
- `RW`, 5, register-number width.

Ports:
- `clk`  in  1  pipeline clock; shadow registers update on the falling edge, matching the control pipeline.
- `reset`  in  1  asynchronous, active-high.
- `Op`  in  6  opcode of the instruction in ID.
- `rs`, `rt`, `rd`  in  RW each  register fields of the instruction in ID.
- `MemRead_out_1`  in  1  MemRead of the instruction in EX.
- `RegWrite_out_2`  in  1  RegWrite of the instruction in MEM.
- `RegWrite_out`  in  1  RegWrite of the instruction in WB.
- `branch_taken`  in  1  EX-stage BEQ/BNE resolved taken.
- `BranchJ_out`  in  1  J decoded in ID.
- `control_stall`  out  1  insert bubble into ID/EX (load-use or RAW stall).
- `control_stall_branch`  out  1  squash ID/EX for a taken branch.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID update enable.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `forward_a`, `forward_b`  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

## Operation
- ID destination `dst_id`: `rd` for Op 000000; `rt` for LW, ADDI, ANDI, ORI, XORI, SLTI; 0 otherwise (SW, BEQ, BNE, J). Destination 0 means no write.
- `rt` is a source only for R, BEQ, BNE, SW; `rs` is a source for every opcode except J.
- Shadow pipeline (falling edge): `rs_ex`, `rt_ex`, `dst_ex` load from ID; `dst_mem` ← `dst_ex`; `dst_wb` ← `dst_mem`. When `control_stall` or `control_stall_branch` is 1, `dst_ex`, `rs_ex`, `rt_ex` load 0 (bubble).
- Load-use: `MemRead_out_1` and `dst_ex` ≠ 0 and `dst_ex` equals a source of ID.
- Forward A: 10 if `RegWrite_out_2` and `dst_mem` ≠ 0 and `dst_mem` == `rs_ex`; else 01 if `RegWrite_out` and `dst_wb` ≠ 0 and `dst_wb` == `rs_ex`; else 00. Forward B: same with `rt_ex`. EX/MEM wins over MEM/WB.
- FSM, registered on the falling edge:
  - RUN: all enables 1, no stall. Taken branch → FLUSH. Else hazard → STALL.
  - STALL: `control_stall`=1, `pc_write`=`ifid_write`=0. Re-evaluate the hazard each cycle; stay while it holds, else → RUN.
  - FLUSH: `control_stall_branch`=1, `ifid_flush`=1, `pc_write`=1; one cycle, then → RUN.
- Hazard detection and the FLUSH/STALL outputs are also asserted combinationally in RUN during the detecting cycle, so the bubble enters at that same falling edge.
- Priority: `branch_taken` over load-use/RAW stall, which is discarded because the ID instruction is squashed. `BranchJ_out` asserts `ifid_flush` only and does not change state. If `BranchJ_out` and a stall occur together, the stall wins and J is re-evaluated next cycle.

## Timing
- Reset values: state RUN, all shadow registers 0, `control_stall`=0, `control_stall_branch`=0, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, forward selects 00.
- Reset mid-stall or mid-flush returns to RUN immediately, asynchronously.
- Load-use stall lasts exactly 1 cycle with forwarding enabled.
- Taken-branch penalty is 2 cycles: the IF/ID and ID/EX contents are squashed.
- Forward selects are combinational from the shadow registers and RegWrite taps, with zero latency.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding active as above; only load-use stalls.
- Undefined: `forward_a`/`forward_b` are tied to 00. A hazard is any ID source matching a non-zero `dst_ex`, `dst_mem` or `dst_wb` whose RegWrite is set (for `dst_ex`, `dst_ex` ≠ 0 suffices). The unit stalls in STALL until no match remains, up to 3 cycles.

## Test plan
- LW $2 followed by ADD $3,$2,$4 → `control_stall`=1 and `pc_write`=0 for exactly 1 cycle; then `forward_a`=01 for the ADD in EX.
- ADD $5,$1,$1 followed by SUB $6,$5,$5 → no stall; `forward_a`=`forward_b`=10 in SUB's EX cycle.
- ADD $5 then ADD $5 then OR $7,$5,$0 → `forward_a`=10, not 01 (newest wins).
- Write to $0 followed by a read of $0 → no forward, no stall.
- BEQ taken in EX while the ID instruction is a load-use hazard → `control_stall_branch`=1, `ifid_flush`=1, `control_stall`=0; RUN after 1 cycle.
- Reset asserted in STALL → all outputs at reset values before the next clock edge. Without `HAZARD_FWD_EN`, the ADD $5 / SUB $6,$5 dependency → 3-cycle stall.
